// File: rtl/axi4l_pkg.sv
// Shared types and default sizing for the AXI4-Lite parameterised RAM.
package axi4l_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  localparam int DEF_AW   = 32;
  localparam int DEF_DW   = 32;
  localparam int DEF_SIZE = 'h1000;

  typedef logic [DEF_AW-1:0] addr_t;

endpackage

// File: rtl/axi4l_ram_param_if.sv
// AXI4-Lite bus bundle; the RAM sits on the slave modport.
interface axi4l_ram_param_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          awvalid, awready;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          wvalid, wready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic          arvalid, arready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;

  modport slave (
    input  awvalid, awaddr, awprot, output awready,
    input  wvalid, wdata, wstrb,    output wready,
    output bvalid, bresp,           input  bready,
    input  arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp,    input  rready
  );

  modport master (
    output awvalid, awaddr, awprot, input  awready,
    output wvalid, wdata, wstrb,    input  wready,
    input  bvalid, bresp,           output bready,
    output arvalid, araddr, arprot, input  arready,
    input  rvalid, rdata, rresp,    output rready
  );
endinterface

// File: rtl/axi4l_ram_mem.sv
// Word-addressed RAM: one byte-enabled write port, one read-first read port,
// registered read data (one-cycle latency). Contents are never reset.
module axi4l_ram_mem #(
  parameter  int DEPTH = 1024,
  parameter  int DW    = 32,
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int SB    = DW / 8
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [SB-1:0] wstrb_i,
  input  logic          re_i,
  input  logic [IW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Byte-lane write; same-edge read sees the pre-write word.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < SB; b++)
        if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
    end
  end

  // Read register only moves on a read, so it holds under R back-pressure.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)  rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/axi4l_ram_param.sv
// AXI4-Lite slave RAM: AW/W holding registers, B/R response slots, storage in
// axi4l_ram_mem. Define AXI4L_RAM_SLVERR_EN to answer out-of-range addresses
// with SLVERR (writes dropped, reads return 0); otherwise addresses wrap.
module axi4l_ram_param import axi4l_pkg::*; #(
  parameter int SIZE = DEF_SIZE,
  parameter int DW   = DEF_DW,
  parameter int AW   = DEF_AW
) (
  input  logic aclk,
  input  logic aresetn,
  axi4l_ram_param_if.slave axi
);
  localparam int SB    = DW / 8;
  localparam int LB    = $clog2(SB);
  localparam int LS    = $clog2(SIZE);
  localparam int IW    = (LS > LB) ? LS - LB : 1;
  localparam int DEPTH = SIZE / SB;

  logic          aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SB-1:0] wstrb_q, wstrb_d;
  logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d, rerr_q, rerr_d;
  resp_t         bresp_q, bresp_d, rresp_q, rresp_d;

  logic          aw_hs, w_hs, wr_fire, rd_fire, aw_err, ar_err;
  logic          wr_resp_stall, rd_resp_stall;
  logic          valid_write_address, valid_write_data;
  logic [IW-1:0] waddr, raddr;
  logic [DW-1:0] wdata, mem_rdata;
  logic [SB-1:0] wstrb;

  assign valid_write_address = aw_held_q;
  assign valid_write_data    = w_held_q;
  assign wr_resp_stall       = bvalid_q & ~axi.bready;
  assign rd_resp_stall       = rvalid_q & ~axi.rready;

  assign wr_fire     = aw_held_q & w_held_q & ~wr_resp_stall;
  assign axi.awready = ~aw_held_q | wr_fire;
  assign axi.wready  = ~w_held_q | wr_fire;
  assign axi.arready = ~rd_resp_stall;
  assign aw_hs       = axi.awvalid & axi.awready;
  assign w_hs        = axi.wvalid & axi.wready;
  assign rd_fire     = axi.arvalid & axi.arready;

  assign waddr = awaddr_q[LB +: IW];
  assign raddr = axi.araddr[LB +: IW];
  assign wdata = wdata_q;
  assign wstrb = wstrb_q;

`ifdef AXI4L_RAM_SLVERR_EN
  localparam logic [AW-1:0] SIZE_A = AW'(SIZE);
  assign aw_err = (awaddr_q >= SIZE_A);
  assign ar_err = (axi.araddr >= SIZE_A);
`else
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
`endif

  // prot and the sub-word/high address bits carry no meaning here
  logic unused_ok;
  assign unused_ok = ^{axi.awprot, axi.arprot, awaddr_q, axi.araddr};

  // Next state for holding registers and response slots.
  always_comb begin
    aw_held_d = aw_held_q;
    awaddr_d  = awaddr_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rerr_d    = rerr_q;
    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = axi.awaddr;
    end else if (wr_fire) aw_held_d = 1'b0;
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = axi.wdata;
      wstrb_d  = axi.wstrb;
    end else if (wr_fire) w_held_d = 1'b0;
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = aw_err ? SLVERR : OKAY;
    end else if (!wr_resp_stall) bvalid_d = 1'b0;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rresp_d  = ar_err ? SLVERR : OKAY;
      rerr_d   = ar_err;
    end else if (!rd_resp_stall) rvalid_d = 1'b0;
  end

  // Control state: cleared by reset, which also drops in-flight transactions.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rerr_q    <= 1'b0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rerr_q    <= rerr_d;
    end
  end

  // Payload registers; only meaningful while the matching held bit is set.
  always_ff @(posedge aclk) begin
    awaddr_q <= awaddr_d;
    wdata_q  <= wdata_d;
    wstrb_q  <= wstrb_d;
  end

  axi4l_ram_mem #(.DEPTH(DEPTH), .DW(DW)) u_mem (
    .clk_i   (aclk),
    .rst_n_i (aresetn),
    .we_i    (wr_fire & ~aw_err & aresetn),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .wstrb_i (wstrb),
    .re_i    (rd_fire & aresetn),
    .raddr_i (raddr),
    .rdata_o (mem_rdata)
  );

  assign axi.bvalid = bvalid_q;
  assign axi.bresp  = bresp_q;
  assign axi.rvalid = rvalid_q;
  assign axi.rresp  = rresp_q;
  assign axi.rdata  = rerr_q ? '0 : mem_rdata;
endmodule
